// File: rtl/prom_access_seq_if.sv
// Pin-side and ROM-side signals of the 6301 PROM access sequencer.
// The master side is the bus pins plus the ROM lookup. The slave side is the sequencer.
interface prom_access_seq_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] addr;
  logic              ce1_n;
  logic              ce2_n;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] data;
  logic              oe_n;

  modport master (
    output addr, ce1_n, ce2_n, rom_data,
    input  rom_addr, data, oe_n
  );

  modport slave (
    input  addr, ce1_n, ce2_n, rom_data,
    output rom_addr, data, oe_n
  );
endinterface

// File: rtl/prom_access_seq.sv
// Access sequencer between the asynchronous 6301 bus pins and a combinational ROM lookup.
// It synchronizes the pins, waits a programmable access time, and holds data/oe_n after deselect.
module prom_access_seq #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int ACCESS_CYCLES = 3,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  prom_access_seq_if.slave  bus
);

  localparam int CNT_MAX_AH = (ACCESS_CYCLES > HOLD_CYCLES) ? ACCESS_CYCLES : HOLD_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_AH > 2) ? CNT_MAX_AH : 2;
  localparam int CNT_W      = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
  localparam bit               HOLD_EN     = (HOLD_CYCLES > 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] VALID  = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [ADDR_W-1:0] addr_sync_r [SYNC_STAGES];
  logic [1:0]        ce_sync_r   [SYNC_STAGES];

  logic [ADDR_W-1:0] addr_s;
  logic              sel_s;
  logic              addr_chg_s;

  logic [1:0]        state_r,    state_nxt_s;
  logic [CNT_W-1:0]  cnt_r,      cnt_nxt_s;
  logic              reaccess_r, reaccess_nxt_s;
  logic [ADDR_W-1:0] rom_addr_r, rom_addr_nxt_s;
  logic [DATA_W-1:0] data_r,     data_nxt_s;
  logic              oe_n_r,     oe_n_nxt_s;

  // The buffer is driven in VALID and HOLD, and also in ACCESS when it is a re-access of a selected device.
  function automatic logic is_driving(input logic [1:0] st, input logic re);
    logic drv;
    case (st)
      VALID:   drv = 1'b1;
      HOLD:    drv = 1'b1;
      ACCESS:  drv = re;
      default: drv = 1'b0;
    endcase
    return drv;
  endfunction

  // Pin synchronizer chains; on reset they read as deselected with address zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_sync_r[i] <= '0;
        ce_sync_r[i]   <= 2'b11;
      end
    end else begin
      addr_sync_r[0] <= bus.addr;
      ce_sync_r[0]   <= {bus.ce2_n, bus.ce1_n};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        addr_sync_r[i] <= addr_sync_r[i-1];
        ce_sync_r[i]   <= ce_sync_r[i-1];
      end
    end
  end

  assign addr_s     = addr_sync_r[SYNC_STAGES-1];
  assign sel_s      = ~ce_sync_r[SYNC_STAGES-1][0] & ~ce_sync_r[SYNC_STAGES-1][1];
  assign addr_chg_s = (addr_s != rom_addr_r);

  // Next-state and datapath decode for the access/valid/hold sequence
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    reaccess_nxt_s = reaccess_r;
    rom_addr_nxt_s = rom_addr_r;
    data_nxt_s     = data_r;
    case (state_r)
      IDLE: begin
        if (sel_s) begin
          rom_addr_nxt_s = addr_s;
          cnt_nxt_s      = ACCESS_LOAD;
          reaccess_nxt_s = 1'b0;
          state_nxt_s    = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (!sel_s) begin
          if (reaccess_r && HOLD_EN) begin
            cnt_nxt_s   = HOLD_LOAD;
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (addr_chg_s) begin
          rom_addr_nxt_s = addr_s;
          cnt_nxt_s      = ACCESS_LOAD;
        end else if (cnt_r == '0) begin
          data_nxt_s  = bus.rom_data;
          state_nxt_s = VALID;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      VALID: begin
        if (!sel_s) begin
          if (HOLD_EN) begin
            cnt_nxt_s   = HOLD_LOAD;
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (addr_chg_s) begin
          rom_addr_nxt_s = addr_s;
          cnt_nxt_s      = ACCESS_LOAD;
          reaccess_nxt_s = 1'b1;
          state_nxt_s    = ACCESS;
        end else begin
          state_nxt_s = VALID;
        end
      end
      HOLD: begin
        if (sel_s) begin
          rom_addr_nxt_s = addr_s;
          cnt_nxt_s      = ACCESS_LOAD;
          reaccess_nxt_s = 1'b1;
          state_nxt_s    = ACCESS;
        end else if (cnt_r == '0) begin
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    // oe_n stays low for one more cycle after leaving a driving state, which gives the HOLD+1 release
    oe_n_nxt_s = ~(is_driving(state_nxt_s, reaccess_nxt_s) | is_driving(state_r, reaccess_r));
  end

  // Sequencer registers; oe_n and data come straight from flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      reaccess_r <= 1'b0;
      rom_addr_r <= '0;
      data_r     <= '0;
      oe_n_r     <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      reaccess_r <= reaccess_nxt_s;
      rom_addr_r <= rom_addr_nxt_s;
      data_r     <= data_nxt_s;
      oe_n_r     <= oe_n_nxt_s;
    end
  end

  assign bus.rom_addr = rom_addr_r;
  assign bus.data     = data_r;
  assign bus.oe_n     = oe_n_r;

endmodule

// File: tb/tb_prom_access_seq.sv
// Directed bench for prom_access_seq: default build plus HOLD_CYCLES=0 and ACCESS_CYCLES=1 builds on shared pins.
module tb_prom_access_seq;

  logic       clk;
  logic       reset;
  logic [7:0] addr;
  logic       ce1_n;
  logic       ce2_n;

  int checks = 0;
  int errors = 0;

  prom_access_seq_if #(.ADDR_W(8), .DATA_W(4)) bus0 ();
  prom_access_seq_if #(.ADDR_W(8), .DATA_W(4)) bus_h0 ();
  prom_access_seq_if #(.ADDR_W(8), .DATA_W(4)) bus_a1 ();

  function automatic logic [3:0] rom_fn(input logic [7:0] a);
    logic [3:0] d;
    case (a)
      8'h12:   d = 4'hA;
      8'h34:   d = 4'h3;
      8'h56:   d = 4'h6;
      default: d = a[3:0] ^ a[7:4];
    endcase
    return d;
  endfunction

  assign bus0.addr       = addr;
  assign bus0.ce1_n      = ce1_n;
  assign bus0.ce2_n      = ce2_n;
  assign bus0.rom_data   = rom_fn(bus0.rom_addr);
  assign bus_h0.addr     = addr;
  assign bus_h0.ce1_n    = ce1_n;
  assign bus_h0.ce2_n    = ce2_n;
  assign bus_h0.rom_data = rom_fn(bus_h0.rom_addr);
  assign bus_a1.addr     = addr;
  assign bus_a1.ce1_n    = ce1_n;
  assign bus_a1.ce2_n    = ce2_n;
  assign bus_a1.rom_data = rom_fn(bus_a1.rom_addr);

  prom_access_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  prom_access_seq #(.HOLD_CYCLES(0)) u_dut_h0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_h0.slave)
  );

  prom_access_seq #(.ACCESS_CYCLES(1)) u_dut_a1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic       ce1_n;
    logic [7:0] rom_addr;
    logic [3:0] data;
    logic       oe_n;
    logic       oe_n_h0;
    logic       oe_n_a1;
    logic [3:0] data_a1;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    // Row i: pins applied before edge i, outputs expected just after edge i (edge 0 = first edge after reset)
    vecs[0]  = '{8'h12, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0};
    vecs[1]  = '{8'h12, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0};
    vecs[2]  = '{8'h12, 1'b0, 8'h12, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0};
    vecs[3]  = '{8'h12, 1'b0, 8'h12, 4'h0, 1'b1, 1'b1, 1'b0, 4'hA};
    vecs[4]  = '{8'h12, 1'b0, 8'h12, 4'h0, 1'b1, 1'b1, 1'b0, 4'hA};
    vecs[5]  = '{8'h12, 1'b0, 8'h12, 4'hA, 1'b0, 1'b0, 1'b0, 4'hA};
    vecs[6]  = '{8'h12, 1'b0, 8'h12, 4'hA, 1'b0, 1'b0, 1'b0, 4'hA};
    vecs[7]  = '{8'h12, 1'b1, 8'h12, 4'hA, 1'b0, 1'b0, 1'b0, 4'hA};
    vecs[8]  = '{8'h12, 1'b1, 8'h12, 4'hA, 1'b0, 1'b0, 1'b0, 4'hA};
    vecs[9]  = '{8'h12, 1'b1, 8'h12, 4'hA, 1'b0, 1'b0, 1'b0, 4'hA};
    vecs[10] = '{8'h12, 1'b1, 8'h12, 4'hA, 1'b0, 1'b1, 1'b0, 4'hA};
    vecs[11] = '{8'h12, 1'b1, 8'h12, 4'hA, 1'b0, 1'b1, 1'b0, 4'hA};
    vecs[12] = '{8'h12, 1'b1, 8'h12, 4'hA, 1'b1, 1'b1, 1'b1, 4'hA};
    vecs[13] = '{8'h12, 1'b1, 8'h12, 4'hA, 1'b1, 1'b1, 1'b1, 4'hA};

    // Reset held with the device selected: outputs stay at reset values
    reset = 1'b1;
    addr  = 8'h5A;
    ce1_n = 1'b0;
    ce2_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset_rom_addr[%0d]", i), 32'(bus0.rom_addr), 32'h00);
      chk($sformatf("reset_data[%0d]", i), 32'(bus0.data), 32'h0);
      chk($sformatf("reset_oe_n[%0d]", i), 32'(bus0.oe_n), 32'h1);
    end
    reset = 1'b0;

    // Basic read of 0x12 followed by deselect and hold, all three builds
    for (int i = 0; i < 14; i++) begin
      addr  = vecs[i].addr;
      ce1_n = vecs[i].ce1_n;
      tick();
      chk($sformatf("vec%0d_rom_addr", i), 32'(bus0.rom_addr), 32'(vecs[i].rom_addr));
      chk($sformatf("vec%0d_data", i), 32'(bus0.data), 32'(vecs[i].data));
      chk($sformatf("vec%0d_oe_n", i), 32'(bus0.oe_n), 32'(vecs[i].oe_n));
      chk($sformatf("vec%0d_oe_n_h0", i), 32'(bus_h0.oe_n), 32'(vecs[i].oe_n_h0));
      chk($sformatf("vec%0d_oe_n_a1", i), 32'(bus_a1.oe_n), 32'(vecs[i].oe_n_a1));
      chk($sformatf("vec%0d_data_a1", i), 32'(bus_a1.data), 32'(vecs[i].data_a1));
    end

    // Address change while valid: 0x12 -> 0x34, old data driven until the new capture
    ce1_n = 1'b0;
    addr  = 8'h12;
    for (int i = 0; i < 6; i++) tick();
    chk("chg_valid_pre_oe_n", 32'(bus0.oe_n), 32'h0);
    chk("chg_valid_pre_data", 32'(bus0.data), 32'hA);
    addr = 8'h34;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("chg_valid_oe_n[%0d]", i), 32'(bus0.oe_n), 32'h0);
      chk($sformatf("chg_valid_data[%0d]", i), 32'(bus0.data), (i == 5) ? 32'h3 : 32'hA);
      chk($sformatf("chg_valid_rom_addr[%0d]", i), 32'(bus0.rom_addr), (i >= 2) ? 32'h34 : 32'h12);
    end

    // Deselect back to idle, then change address one edge after rom_addr updates
    ce1_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("desel_oe_n[%0d]", i), 32'(bus0.oe_n), (i == 5) ? 32'h1 : 32'h0);
    end
    ce1_n = 1'b0;
    addr  = 8'h56;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_first_rom_addr", 32'(bus0.rom_addr), 32'h56);
    addr = 8'h78;
    for (int i = 3; i < 9; i++) begin
      tick();
      chk($sformatf("mid_rom_addr[e%0d]", i), 32'(bus0.rom_addr), (i >= 5) ? 32'h78 : 32'h56);
      chk($sformatf("mid_oe_n[e%0d]", i), 32'(bus0.oe_n), (i == 8) ? 32'h0 : 32'h1);
      chk($sformatf("mid_data[e%0d]", i), 32'(bus0.data), (i == 8) ? 32'hF : 32'h3);
    end

    // One-edge deselect glitch: default build reselects from HOLD with oe_n held low throughout
    for (int i = 0; i < 10; i++) begin
      ce1_n = (i == 0) ? 1'b1 : 1'b0;
      tick();
      chk($sformatf("reselect_oe_n[%0d]", i), 32'(bus0.oe_n), 32'h0);
      chk($sformatf("reselect_oe_n_h0[%0d]", i), 32'(bus_h0.oe_n), (i >= 3 && i <= 5) ? 32'h1 : 32'h0);
    end
    chk("reselect_data", 32'(bus0.data), 32'hF);

    // Reset in the middle of a re-access, then a clean read of 0x12
    addr = 8'h12;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    chk("midreset_oe_n", 32'(bus0.oe_n), 32'h1);
    chk("midreset_data", 32'(bus0.data), 32'h0);
    chk("midreset_rom_addr", 32'(bus0.rom_addr), 32'h00);
    chk("midreset_oe_n_a1", 32'(bus_a1.oe_n), 32'h1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("postreset_oe_n[%0d]", i), 32'(bus0.oe_n), (i == 5) ? 32'h0 : 32'h1);
      chk($sformatf("postreset_oe_n_a1[%0d]", i), 32'(bus_a1.oe_n), (i >= 3) ? 32'h0 : 32'h1);
    end
    chk("postreset_data", 32'(bus0.data), 32'hA);
    chk("postreset_data_a1", 32'(bus_a1.data), 32'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
